// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the shared-memory port arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  localparam int DEF_PROC_COUNT = 4;
  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LEN_W      = 4;

  // Burst sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // One beat as presented on the memory port (default configuration widths)
  typedef struct packed {
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } mem_beat_t;

  // Increment with wrap at n (used for the round-robin pointer)
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return ((v + 1) >= n) ? 0 : (v + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Round-robin one-hot picker: rotate requests by ptr, take lowest set bit, rotate back.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic [N-1:0]  w_req_rot;
  logic [N-1:0]  w_pick_rot;
  logic [PW-1:0] w_rot_idx;

  // Rotate so that bit 0 is the requester at i_ptr, pick the lowest one, then rotate back
  always_comb begin
    w_req_rot  = '0;
    w_pick_rot = '0;
    w_rot_idx  = '0;
    o_gnt      = '0;
    for (int i = 0; i < N; i++) begin
      w_rot_idx    = PW'((i + int'(i_ptr)) % N);
      w_req_rot[i] = i_req[w_rot_idx];
    end
    w_pick_rot = w_req_rot & (~w_req_rot + {{(N-1){1'b0}}, 1'b1});
    for (int i = 0; i < N; i++) begin
      w_rot_idx        = PW'((i + int'(i_ptr)) % N);
      o_gnt[w_rot_idx] = w_pick_rot[i];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among PROC_COUNT processors; round-robin grant held for a whole burst.
// Latency: grant 1 cycle after request; ack same cycle as beat acceptance; rvalid 1 cycle after a read beat.
// Backpressure: i_mem_ready low holds address/data with no ack; dropping i_req mid-burst aborts it.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int PROC_COUNT = DEF_PROC_COUNT,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic                         i_clk,
  input  logic                         i_rstn,
  input  logic [PROC_COUNT-1:0]        i_req,
  input  logic [PROC_COUNT-1:0]        i_we,
  input  logic [PROC_COUNT*ADDR_W-1:0] i_addr,
  input  logic [PROC_COUNT*LEN_W-1:0]  i_len,
  input  logic [PROC_COUNT*DATA_W-1:0] i_wdata,
  output logic [PROC_COUNT-1:0]        o_gnt,
  output logic [PROC_COUNT-1:0]        o_ack,
  output logic [PROC_COUNT-1:0]        o_rvalid,
  output logic [DATA_W-1:0]            o_rdata,
  output logic                         o_mem_en,
  output logic                         o_mem_we,
  output logic [ADDR_W-1:0]            o_mem_addr,
  output logic [DATA_W-1:0]            o_mem_wdata,
  input  logic                         i_mem_ready,
  input  logic [DATA_W-1:0]            i_mem_rdata
);

  localparam int PW = $clog2(PROC_COUNT);

  arb_state_t            r_state,    w_state_nxt;
  logic [PW-1:0]         r_rr_ptr,   w_rr_ptr_nxt;
  logic [PW-1:0]         r_sel,      w_sel_nxt;
  logic                  r_we,       w_we_nxt;
  logic [ADDR_W-1:0]     r_base,     w_base_nxt;
  logic [LEN_W-1:0]      r_len,      w_len_nxt;
  logic [LEN_W-1:0]      r_beat_cnt, w_beat_cnt_nxt;
  logic [PROC_COUNT-1:0] r_rvalid,   w_rvalid_nxt;

  logic [ADDR_W-1:0]     w_addr_arr  [PROC_COUNT];
  logic [LEN_W-1:0]      w_len_arr   [PROC_COUNT];
  logic [DATA_W-1:0]     w_wdata_arr [PROC_COUNT];

  logic [PROC_COUNT-1:0] w_arb_gnt;
  logic [PW-1:0]         w_arb_idx;
  logic                  w_arb_any;
  logic [PROC_COUNT-1:0] w_sel_oh;
  logic [PW-1:0]         w_sel_inc;
  logic                  w_in_burst;
  logic                  w_req_sel;
  logic                  w_mem_en;
  logic                  w_accept;
  logic                  w_last_beat;
  logic                  w_rd_in_flight;
  logic [ADDR_W-1:0]     w_beat_addr;

  // Unpack the flat per-processor buses so they can be indexed by processor number
  for (genvar g = 0; g < PROC_COUNT; g++) begin : g_unpack
    assign w_addr_arr[g]  = i_addr[g*ADDR_W +: ADDR_W];
    assign w_len_arr[g]   = i_len[g*LEN_W +: LEN_W];
    assign w_wdata_arr[g] = i_wdata[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(
    .N  (PROC_COUNT),
    .PW (PW)
  ) u_rr (
    .i_req (i_req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt)
  );

  assign w_arb_any      = |i_req;
  assign w_sel_oh       = {{(PROC_COUNT-1){1'b0}}, 1'b1} << r_sel;
  assign w_sel_inc      = PW'(wrap_inc(32'(r_sel), PROC_COUNT));
  assign w_in_burst     = (r_state == BURST);
  assign w_req_sel      = i_req[r_sel];
  assign w_mem_en       = w_in_burst & w_req_sel;
  assign w_accept       = w_mem_en & i_mem_ready;
  assign w_last_beat    = (r_beat_cnt == r_len);
  // A registered rvalid this cycle means a read beat was accepted last cycle
  assign w_rd_in_flight = |r_rvalid;
  // Address arithmetic is modulo 2^ADDR_W, so bursts wrap through zero
  assign w_beat_addr    = r_base + {{(ADDR_W-LEN_W){1'b0}}, r_beat_cnt};

  // One-hot winner to processor index
  always_comb begin
    w_arb_idx = '0;
    for (int i = 0; i < PROC_COUNT; i++) begin
      if (w_arb_gnt[i]) w_arb_idx = PW'(i);
    end
  end

  // Next-state and datapath-capture logic for the burst sequencer
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_sel_nxt      = r_sel;
    w_we_nxt       = r_we;
    w_base_nxt     = r_base;
    w_len_nxt      = r_len;
    w_beat_cnt_nxt = r_beat_cnt;
    w_rvalid_nxt   = '0;
    case (r_state)
      IDLE: begin
        if (w_arb_any) begin
          w_sel_nxt      = w_arb_idx;
          w_we_nxt       = i_we[w_arb_idx];
          w_base_nxt     = w_addr_arr[w_arb_idx];
          w_len_nxt      = w_len_arr[w_arb_idx];
          w_beat_cnt_nxt = '0;
          w_state_nxt    = BURST;
        end
      end
      BURST: begin
        if (!w_req_sel) begin
          // Abandoned burst: wait one cycle only if a read return is still due
          if (w_rd_in_flight) begin
            w_state_nxt = DRAIN;
          end else begin
            w_state_nxt  = IDLE;
            w_rr_ptr_nxt = w_sel_inc;
          end
        end else if (w_accept) begin
          w_beat_cnt_nxt = r_beat_cnt + LEN_W'(1);
          if (!r_we) w_rvalid_nxt = w_sel_oh;
          if (w_last_beat) begin
            if (r_we) begin
              w_state_nxt  = IDLE;
              w_rr_ptr_nxt = w_sel_inc;
            end else begin
              w_state_nxt = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        w_state_nxt  = IDLE;
        w_rr_ptr_nxt = w_sel_inc;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and burst-context registers; reset discards any pending read return
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_sel      <= '0;
      r_we       <= 1'b0;
      r_base     <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
      r_rvalid   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_sel      <= w_sel_nxt;
      r_we       <= w_we_nxt;
      r_base     <= w_base_nxt;
      r_len      <= w_len_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_rvalid   <= w_rvalid_nxt;
    end
  end

  assign o_gnt       = (r_state != IDLE) ? w_sel_oh : '0;
  assign o_ack       = w_accept ? w_sel_oh : '0;
  assign o_rvalid    = r_rvalid;
  assign o_rdata     = i_mem_rdata;
  assign o_mem_en    = w_mem_en;
  assign o_mem_we    = w_in_burst & r_we;
  assign o_mem_addr  = w_in_burst ? w_beat_addr : '0;
  assign o_mem_wdata = w_in_burst ? w_wdata_arr[r_sel] : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector tables plus hand-written reset sequences.
// Latency: n/a.
// Backpressure: i_mem_ready is driven per vector to exercise stalls.
module tb_mem_port_arbiter;

  localparam int NP = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 4;

  logic              i_clk;
  logic              i_rstn;
  logic [NP-1:0]     i_req;
  logic [NP-1:0]     i_we;
  logic [NP*AW-1:0]  i_addr;
  logic [NP*LW-1:0]  i_len;
  logic [NP*DW-1:0]  i_wdata;
  logic [NP-1:0]     o_gnt;
  logic [NP-1:0]     o_ack;
  logic [NP-1:0]     o_rvalid;
  logic [DW-1:0]     o_rdata;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [AW-1:0]     o_mem_addr;
  logic [DW-1:0]     o_mem_wdata;
  logic              i_mem_ready;
  logic [DW-1:0]     i_mem_rdata;

  // Per-processor stimulus, packed onto the flat buses below
  logic              cfg_we   [NP];
  logic [AW-1:0]     cfg_addr [NP];
  logic [LW-1:0]     cfg_len  [NP];
  logic [DW-1:0]     wdat     [NP];
  int                beat     [NP];

  for (genvar g = 0; g < NP; g++) begin : g_pack
    assign i_we[g]              = cfg_we[g];
    assign i_addr[g*AW +: AW]   = cfg_addr[g];
    assign i_len[g*LW +: LW]    = cfg_len[g];
    assign i_wdata[g*DW +: DW]  = wdat[g];
  end

  mem_port_arbiter #(
    .PROC_COUNT (NP),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .LEN_W      (LW)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_len       (i_len),
    .i_wdata     (i_wdata),
    .o_gnt       (o_gnt),
    .o_ack       (o_ack),
    .o_rvalid    (o_rvalid),
    .o_rdata     (o_rdata),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ready (i_mem_ready),
    .i_mem_rdata (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [3:0]  rv;
    logic        en;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wd;
    logic        chkwd;
  } vec_t;

  vec_t        vq[$];
  int          n_total;
  int          n_bad;
  logic [15:0] prev_addr;

  function automatic logic [31:0] rd_of(input logic [15:0] a);
    return 32'hA5A5_0000 | {16'h0000, a};
  endfunction

  function automatic logic [31:0] wd_of(input int p, input int b);
    return 32'hC0DE_0000 | 32'(p << 8) | 32'(b);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cfg(input int p, input logic we, input logic [15:0] a, input logic [3:0] l);
    cfg_we[p[1:0]]   = we;
    cfg_addr[p[1:0]] = a;
    cfg_len[p[1:0]]  = l;
  endtask

  task automatic add(input logic [3:0] req, input logic rdy, input logic [3:0] gnt,
                     input logic [3:0] ack, input logic [3:0] rv, input logic en,
                     input logic we, input logic [15:0] addr, input logic [31:0] wd,
                     input logic chkwd);
    vec_t v;
    v = '{req, rdy, gnt, ack, rv, en, we, addr, wd, chkwd};
    vq.push_back(v);
  endtask

  // One cycle: drive at posedge+1, check at negedge, processor reacts to acks
  task automatic run_row(input vec_t v, input string nm, input int idx);
    string t;
    i_req       = v.req;
    i_mem_ready = v.rdy;
    i_mem_rdata = rd_of(prev_addr);
    for (int p = 0; p < NP; p++) wdat[p[1:0]] = wd_of(p, beat[p[1:0]]);
    @(negedge i_clk);
    t = $sformatf("%s[%0d]", nm, idx);
    check({t, ".gnt"},    32'(o_gnt),    32'(v.gnt));
    check({t, ".ack"},    32'(o_ack),    32'(v.ack));
    check({t, ".rvalid"}, 32'(o_rvalid), 32'(v.rv));
    check({t, ".mem_en"}, 32'(o_mem_en), 32'(v.en));
    if (v.en) begin
      check({t, ".mem_we"},   32'(o_mem_we),   32'(v.we));
      check({t, ".mem_addr"}, 32'(o_mem_addr), 32'(v.addr));
    end
    if (v.chkwd) check({t, ".mem_wdata"}, o_mem_wdata, v.wd);
    if (v.rv != 4'b0000) check({t, ".rdata"}, o_rdata, rd_of(prev_addr));
    for (int p = 0; p < NP; p++) if (o_ack[p[1:0]]) beat[p[1:0]]++;
    prev_addr = v.addr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < vq.size(); i++) run_row(vq[i], nm, i);
    vq.delete();
  endtask

  initial begin
    n_total     = 0;
    n_bad       = 0;
    prev_addr   = '0;
    i_rstn      = 1'b0;
    i_req       = '0;
    i_mem_ready = 1'b0;
    i_mem_rdata = '0;
    for (int p = 0; p < NP; p++) begin
      cfg(p, 1'b1, 16'(32'h1000 * (p + 1)), 4'd0);
      beat[p[1:0]] = 0;
      wdat[p[1:0]] = wd_of(p, 0);
    end

    // Reset state
    @(negedge i_clk);
    check("reset.gnt",       32'(o_gnt),      32'h0);
    check("reset.ack",       32'(o_ack),      32'h0);
    check("reset.rvalid",    32'(o_rvalid),   32'h0);
    check("reset.mem_en",    32'(o_mem_en),   32'h0);
    check("reset.mem_we",    32'(o_mem_we),   32'h0);
    check("reset.mem_addr",  32'(o_mem_addr), 32'h0);
    check("reset.mem_wdata", o_mem_wdata,     32'h0);
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;

    // Round-robin fairness: all request single-beat writes, grants 0,1,2,3,0 with bubbles
    add(4'hF, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'hF, 1, 4'h1, 4'h1, 4'h0, 1, 1, 16'h1000, 32'hC0DE_0000, 1);
    add(4'hF, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'hF, 1, 4'h2, 4'h2, 4'h0, 1, 1, 16'h2000, 32'hC0DE_0100, 1);
    add(4'hF, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'hF, 1, 4'h4, 4'h4, 4'h0, 1, 1, 16'h3000, 32'hC0DE_0200, 1);
    add(4'hF, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'hF, 1, 4'h8, 4'h8, 4'h0, 1, 1, 16'h4000, 32'hC0DE_0300, 1);
    add(4'hF, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'hF, 1, 4'h1, 4'h1, 4'h0, 1, 1, 16'h1000, 32'hC0DE_0001, 1);
    add(4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    run_table("rr");

    // Single read by proc1, then pointer must sit at 2 (req 1011 -> proc3 wins)
    cfg(1, 1'b0, 16'h0100, 4'd3);
    add(4'h2, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'h2, 1, 4'h2, 4'h2, 4'h0, 1, 0, 16'h0100, 32'h0,         0);
    add(4'h2, 1, 4'h2, 4'h2, 4'h2, 1, 0, 16'h0101, 32'h0,         0);
    add(4'h2, 1, 4'h2, 4'h2, 4'h2, 1, 0, 16'h0102, 32'h0,         0);
    add(4'h2, 1, 4'h2, 4'h2, 4'h2, 1, 0, 16'h0103, 32'h0,         0);
    add(4'h0, 1, 4'h2, 4'h0, 4'h2, 0, 0, 16'h0000, 32'h0,         0);
    add(4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'hB, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'hB, 1, 4'h8, 4'h8, 4'h0, 1, 1, 16'h4000, 32'hC0DE_0301, 1);
    add(4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    run_table("rd");

    // Stall: proc0 write len=1, memory not ready for 3 cycles on beat 0
    cfg(0, 1'b1, 16'h0200, 4'd1);
    add(4'h1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'h1, 0, 4'h1, 4'h0, 4'h0, 1, 1, 16'h0200, 32'hC0DE_0002, 1);
    add(4'h1, 0, 4'h1, 4'h0, 4'h0, 1, 1, 16'h0200, 32'hC0DE_0002, 1);
    add(4'h1, 0, 4'h1, 4'h0, 4'h0, 1, 1, 16'h0200, 32'hC0DE_0002, 1);
    add(4'h1, 1, 4'h1, 4'h1, 4'h0, 1, 1, 16'h0200, 32'hC0DE_0002, 1);
    add(4'h1, 1, 4'h1, 4'h1, 4'h0, 1, 1, 16'h0201, 32'hC0DE_0003, 1);
    add(4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    run_table("stall");

    // Address wrap: proc1 read from 0xFFFE, 4 beats
    cfg(1, 1'b0, 16'hFFFE, 4'd3);
    add(4'h2, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'h2, 1, 4'h2, 4'h2, 4'h0, 1, 0, 16'hFFFE, 32'h0,         0);
    add(4'h2, 1, 4'h2, 4'h2, 4'h2, 1, 0, 16'hFFFF, 32'h0,         0);
    add(4'h2, 1, 4'h2, 4'h2, 4'h2, 1, 0, 16'h0000, 32'h0,         0);
    add(4'h2, 1, 4'h2, 4'h2, 4'h2, 1, 0, 16'h0001, 32'h0,         0);
    add(4'h0, 1, 4'h2, 4'h0, 4'h2, 0, 0, 16'h0000, 32'h0,         0);
    add(4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    run_table("wrap");

    // Abort: proc2 read len=7 drops request after 2 beats; pointer then at 3
    cfg(2, 1'b0, 16'h0300, 4'd7);
    add(4'h4, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'h4, 1, 4'h4, 4'h4, 4'h0, 1, 0, 16'h0300, 32'h0,         0);
    add(4'h4, 1, 4'h4, 4'h4, 4'h4, 1, 0, 16'h0301, 32'h0,         0);
    add(4'h0, 1, 4'h4, 4'h0, 4'h4, 0, 0, 16'h0000, 32'h0,         0);
    add(4'h0, 1, 4'h4, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'hF, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'hF, 1, 4'h8, 4'h8, 4'h0, 1, 1, 16'h4000, 32'hC0DE_0302, 1);
    add(4'h0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    run_table("abort");

    // Reset mid-burst: proc0 write len=3, reset asserted during beat 2
    cfg(0, 1'b1, 16'h0500, 4'd3);
    add(4'h1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 16'h0000, 32'h0,         0);
    add(4'h1, 1, 4'h1, 4'h1, 4'h0, 1, 1, 16'h0500, 32'h0,         0);
    add(4'h1, 1, 4'h1, 4'h1, 4'h0, 1, 1, 16'h0501, 32'h0,         0);
    run_table("rstmid");
    i_req       = 4'h1;
    i_mem_ready = 1'b1;
    #2;
    check("rstmid.beat2_en",   32'(o_mem_en),   32'h1);
    check("rstmid.beat2_addr", 32'(o_mem_addr), 32'h0502);
    i_rstn = 1'b0;
    #1;
    check("rstmid.async_en",  32'(o_mem_en), 32'h0);
    check("rstmid.async_gnt", 32'(o_gnt),    32'h0);
    check("rstmid.async_ack", 32'(o_ack),    32'h0);
    @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    cfg(1, 1'b1, 16'h2000, 4'd0);
    i_req = 4'hF;
    @(negedge i_clk);
    check("rstmid.idle_gnt", 32'(o_gnt), 32'h0);
    @(posedge i_clk);
    #1;
    @(negedge i_clk);
    check("rstmid.ptr0_gnt", 32'(o_gnt),    32'h1);
    check("rstmid.ptr0_en",  32'(o_mem_en), 32'h1);
    @(posedge i_clk);
    #1;
    i_req = 4'h0;
    @(posedge i_clk);
    #1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
